// File: rtl/note_select.sv
// Key/octave/mode front end for the synth voice path.
// Debounces raw buttons and emits a registered divider/mode pair.
module note_select #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] keys,
  input  logic        oct_up,
  input  logic        oct_down,
  input  logic        mode_btn,
  output logic [17:0] divider,
  output logic [1:0]  mode,
  output logic        note_on,
  output logic        note_strobe
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
    $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  logic [15:0]   raw, s1, s2, prev, deb, agree;
  logic [CW-1:0] cnt;
  logic          tick;

  assign raw   = {mode_btn, oct_down, oct_up, keys};
  assign tick  = (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign agree = ~(s2 ^ prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      deb  <= '0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (tick) begin
        cnt  <= '0;
        prev <= s2;
        deb  <= (agree & s2) | (~agree & deb);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  logic [3:0] win_idx;

  always_comb begin
    win_idx = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (deb[i]) win_idx = 4'(i);
    end
  end

  logic [2:0] btn_q;
  logic       up_p, dn_p, md_p;
  logic       key_any;
  logic [3:0] key_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q   <= '0;
      up_p    <= 1'b0;
      dn_p    <= 1'b0;
      md_p    <= 1'b0;
      key_any <= 1'b0;
      key_idx <= '0;
    end else begin
      btn_q   <= deb[15:13];
      up_p    <= deb[13] & ~btn_q[0];
      dn_p    <= deb[14] & ~btn_q[1];
      md_p    <= deb[15] & ~btn_q[2];
      key_any <= |deb[12:0];
      key_idx <= win_idx;
    end
  end

  logic [2:0] octave;

  always_ff @(posedge clk) begin
    if (rst) begin
      octave <= 3'd4;
      mode   <= 2'd0;
    end else begin
      if (up_p && !dn_p && octave != 3'd6)
        octave <= octave + 3'd1;
      else if (dn_p && !up_p && octave != 3'd2)
        octave <= octave - 3'd1;
      if (md_p) mode <= mode + 2'd1;
    end
  end

  function automatic logic [15:0] base(input logic [3:0] i);
    case (i)
      4'd0:    base = 16'd38223;
      4'd1:    base = 16'd36077;
      4'd2:    base = 16'd34052;
      4'd3:    base = 16'd32141;
      4'd4:    base = 16'd30337;
      4'd5:    base = 16'd28635;
      4'd6:    base = 16'd27028;
      4'd7:    base = 16'd25511;
      4'd8:    base = 16'd24079;
      4'd9:    base = 16'd22727;
      4'd10:   base = 16'd21452;
      4'd11:   base = 16'd20248;
      4'd12:   base = 16'd19111;
      default: base = 16'd38223;
    endcase
  endfunction

  logic [17:0] b18, target;

  assign b18 = {2'b00, base(key_idx)};

  always_comb begin
    case (octave)
      3'd2:    target = b18 << 2;
      3'd3:    target = b18 << 1;
      3'd5:    target = b18 >> 1;
      3'd6:    target = b18 >> 2;
      default: target = b18;
    endcase
  end

  state_t      state, state_d;
  logic [17:0] divider_d;
  logic        note_on_d, strobe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      divider     <= 18'd38223;
      note_on     <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      state       <= state_d;
      divider     <= divider_d;
      note_on     <= note_on_d;
      note_strobe <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state;
    divider_d = divider;
    note_on_d = 1'b0;
    strobe_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_any) begin
          state_d   = PLAY;
          divider_d = target;
          note_on_d = 1'b1;
          strobe_d  = 1'b1;
        end
      end
      PLAY: begin
        if (!key_any) begin
          state_d = IDLE;
        end else begin
          note_on_d = 1'b1;
          if (target != divider) begin
            divider_d = target;
            strobe_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_note_select.sv
// Scoreboard bench for note_select.
// Expected strobed dividers and mode values are queued ahead.
module tb_note_select;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] keys = '0;
  logic        oct_up = 1'b0;
  logic        oct_down = 1'b0;
  logic        mode_btn = 1'b0;
  logic [17:0] divider;
  logic [1:0]  mode;
  logic        note_on;
  logic        note_strobe;

  note_select #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .oct_up      (oct_up),
    .oct_down    (oct_down),
    .mode_btn    (mode_btn),
    .divider     (divider),
    .mode        (mode),
    .note_on     (note_on),
    .note_strobe (note_strobe)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [17:0] exp_div[$];
  logic [1:0]  exp_mode[$];
  bit          mon_en = 1'b0;
  logic [1:0]  prev_mode = 2'd0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (note_strobe) begin
        if (exp_div.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected actual=%0d expected=none",
                   divider);
        end else begin
          check("strobe_div", int'(divider), int'(exp_div.pop_front()));
        end
      end
      if (mode != prev_mode) begin
        if (exp_mode.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mode_unexpected actual=%0d expected=none", mode);
        end else begin
          check("mode_step", int'(mode), int'(exp_mode.pop_front()));
        end
        prev_mode = mode;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit u, input bit d, input bit m);
    oct_up   = u;
    oct_down = d;
    mode_btn = m;
    cyc(20);
    oct_up   = 1'b0;
    oct_down = 1'b0;
    mode_btn = 1'b0;
    cyc(20);
  endtask

  initial begin
    cyc(2);
    check("rst_divider", int'(divider), 38223);
    check("rst_mode", int'(mode), 0);
    check("rst_note_on", int'(note_on), 0);
    check("rst_strobe", int'(note_strobe), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    exp_div.push_back(18'd22727);
    keys = 13'h0200;
    cyc(30);
    check("a4_note_on", int'(note_on), 1);
    check("a4_divider", int'(divider), 22727);
    keys = '0;
    cyc(30);
    check("rel_note_on", int'(note_on), 0);
    check("rel_divider", int'(divider), 22727);

    exp_div.push_back(18'd19111);
    keys = 13'h1001;
    cyc(30);
    check("prio_divider", int'(divider), 19111);
    keys = '0;
    cyc(30);

    keys = 13'h0020;
    cyc(2);
    keys = '0;
    cyc(30);
    check("glitch_note_on", int'(note_on), 0);
    check("glitch_divider", int'(divider), 19111);

    exp_div.push_back(18'd22727);
    keys = 13'h0200;
    cyc(30);
    exp_div.push_back(18'd11363);
    press(1, 0, 0);
    exp_div.push_back(18'd5681);
    press(1, 0, 0);
    press(1, 0, 0);
    check("oct6_divider", int'(divider), 5681);

    exp_div.push_back(18'd11363);
    exp_div.push_back(18'd22727);
    exp_div.push_back(18'd45454);
    exp_div.push_back(18'd90908);
    repeat (5) press(0, 1, 0);
    check("oct2_divider", int'(divider), 90908);

    exp_mode.push_back(2'd1);
    exp_mode.push_back(2'd2);
    exp_mode.push_back(2'd3);
    exp_mode.push_back(2'd0);
    exp_mode.push_back(2'd1);
    repeat (5) press(0, 0, 1);
    check("mode_final", int'(mode), 1);

    press(1, 1, 0);
    check("both_divider", int'(divider), 90908);

    exp_div.push_back(18'd45454);
    repeat (10) begin
      oct_up = ~oct_up;
      cyc(1);
    end
    oct_up = 1'b1;
    cyc(20);
    oct_up = 1'b0;
    cyc(20);
    check("bounce_divider", int'(divider), 45454);

    exp_mode.push_back(2'd0);
    exp_div.push_back(18'd22727);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_divider", int'(divider), 38223);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_note_on", int'(note_on), 0);
    check("mid_rst_strobe", int'(note_strobe), 0);
    cyc(30);
    check("post_rst_note_on", int'(note_on), 1);
    check("post_rst_divider", int'(divider), 22727);
    keys = '0;
    cyc(30);

    check("div_queue_left", exp_div.size(), 0);
    check("mode_queue_left", exp_mode.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
